inst_rom_loader: RTL and testbench



---
 rtl/inst_rom_loader_if.sv | 32 +++
 rtl/inst_rom_loader.sv | 132 +++++++++++++
 tb/tb_inst_rom_loader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_rom_loader_if.sv
// Fetch + byte-load bus for inst_rom_loader.
//   fetch : rom_ce_i, rom_addr_i -> rom_data_o (combinational)
//   load  : ld_start_i, ld_run_i, ld_valid_i, ld_byte_i, ld_last_i -> ld_ready_o
//   status: ld_done_o, ld_err_o, word_count_o, cpu_rst_o
// master = core/host side, slave = loader.
interface inst_rom_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rom_ce_i;
  logic [31:0]       rom_addr_i;
  logic [31:0]       rom_data_o;
  logic              ld_start_i;
  logic              ld_run_i;
  logic              ld_valid_i;
  logic [7:0]        ld_byte_i;
  logic              ld_last_i;
  logic              ld_ready_o;
  logic              ld_done_o;
  logic              ld_err_o;
  logic [ADDR_W:0]   word_count_o;
  logic              cpu_rst_o;

  modport master (
    output rom_ce_i, rom_addr_i, ld_start_i, ld_run_i, ld_valid_i, ld_byte_i, ld_last_i,
    input  rom_data_o, ld_ready_o, ld_done_o, ld_err_o, word_count_o, cpu_rst_o
  );

  modport slave (
    input  rom_ce_i, rom_addr_i, ld_start_i, ld_run_i, ld_valid_i, ld_byte_i, ld_last_i,
    output rom_data_o, ld_ready_o, ld_done_o, ld_err_o, word_count_o, cpu_rst_o
  );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction ROM with a byte-serial big-endian loader. Holds the core in
// reset (cpu_rst_o) until an image is loaded or a run is requested, then
// serves fetches combinationally.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : inst_rom_loader_if slave (fetch port, load port, status)
//
// state | meaning
// IDLE  | after reset, core held in reset
// LOAD  | accepting image bytes, core held in reset
// RUN   | core executing, fetch port live
module inst_rom_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  inst_rom_loader_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [ADDR_W:0]   waddr;
  logic [ADDR_W:0]   word_count;
  logic [31:0]       shreg;
  logic              cpu_rst_q;
  logic              done_q;
  logic              err_q;
  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              full;
  logic              wr_en;
  logic [31:0]       lane_word;
  logic [31:0]       asm_word;
  logic [ADDR_W:0]   one;

  assign one       = {{ADDR_W{1'b0}}, 1'b1};
  assign accept    = bus.ld_valid_i && (state == LOAD);
  // waddr saturates at DEPTH, so its top bit alone marks a full memory
  assign full      = waddr[ADDR_W];
  // place the incoming byte in its big-endian lane; earlier lanes live in shreg
  assign lane_word = {bus.ld_byte_i, 24'h0} >> {byte_cnt, 3'b000};
  assign asm_word  = shreg | lane_word;
  assign wr_en     = accept && !full && ((byte_cnt == 2'd3) || bus.ld_last_i);

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[waddr[ADDR_W-1:0]] <= asm_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      word_count <= '0;
      byte_cnt   <= '0;
      waddr      <= '0;
      shreg      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ld_start_i) begin
            state      <= LOAD;
            err_q      <= 1'b0;
            word_count <= '0;
            byte_cnt   <= '0;
            waddr      <= '0;
            shreg      <= '0;
          end else if (bus.ld_run_i) begin
            state     <= RUN;
            cpu_rst_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            if (full) begin
              err_q <= 1'b1;
            end else if (wr_en) begin
              shreg      <= '0;
              byte_cnt   <= '0;
              waddr      <= waddr + one;
              word_count <= word_count + one;
            end else begin
              shreg    <= asm_word;
              byte_cnt <= byte_cnt + 2'd1;
            end
            if (bus.ld_last_i) begin
              state     <= RUN;
              cpu_rst_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.ld_start_i) begin
            state      <= LOAD;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            word_count <= '0;
            byte_cnt   <= '0;
            waddr      <= '0;
            shreg      <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          cpu_rst_q <= 1'b1;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ld_ready_o   = (state == LOAD);
  assign bus.ld_done_o    = done_q;
  assign bus.ld_err_o     = err_q;
  assign bus.cpu_rst_o    = cpu_rst_q;
  assign bus.word_count_o = word_count;
  assign bus.rom_data_o   = (bus.rom_ce_i && (state == RUN)) ?
                            mem[bus.rom_addr_i[ADDR_W+1:2]] : 32'h0;

  // byte-lane and above-depth address bits are intentionally ignored (aliasing)
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, bus.rom_addr_i[31:ADDR_W+2], bus.rom_addr_i[1:0]};
endmodule

// File: tb/tb_inst_rom_loader.sv
module tb_inst_rom_loader;
  logic clk;
  logic rst;

  inst_rom_loader_if #(.ADDR_W(10)) ifa ();
  inst_rom_loader_if #(.ADDR_W(2))  ifb ();

  inst_rom_loader #(.ADDR_W(10)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  inst_rom_loader #(.ADDR_W(2))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // model: 0=idle 1=load 2=run
  int          m_st    [2];
  int          m_wc    [2];
  bit          m_err   [2];
  int          m_nb    [2];
  logic [7:0]  m_pb    [2][4];
  logic [31:0] m_mem   [2][1024];
  bit          m_vld   [2][1024];
  int          m_depth [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_clear(input int k);
    m_wc[k] = 0; m_err[k] = 0; m_nb[k] = 0;
    for (int j = 0; j < 4; j++) m_pb[k][j] = 8'h0;
  endtask

  task automatic model_step(input int k, input logic r, input logic start, input logic run,
                            input logic valid, input logic [7:0] b, input logic last);
    logic [31:0] w;
    if (r) begin
      m_st[k] = 0;
      m_clear(k);
    end else if (m_st[k] == 0) begin
      if (start) begin m_st[k] = 1; m_clear(k); end
      else if (run) m_st[k] = 2;
    end else if (m_st[k] == 1) begin
      if (valid) begin
        if (m_wc[k] == m_depth[k]) m_err[k] = 1;
        else begin
          m_pb[k][m_nb[k]] = b;
          m_nb[k]++;
          if (m_nb[k] == 4 || last) begin
            w = {m_pb[k][0], m_pb[k][1], m_pb[k][2], m_pb[k][3]};
            m_mem[k][m_wc[k]] = w;
            m_vld[k][m_wc[k]] = 1;
            m_wc[k]++;
            m_nb[k] = 0;
            for (int j = 0; j < 4; j++) m_pb[k][j] = 8'h0;
          end
        end
        if (last) m_st[k] = 2;
      end
    end else begin
      if (start) begin m_st[k] = 1; m_clear(k); end
    end
  endtask

  task automatic compare(input int k, input logic ce, input logic [31:0] addr,
                         input logic [31:0] data, input logic ready, input logic done,
                         input logic err, input logic [31:0] wc, input logic crst);
    int idx;
    chk($sformatf("dut%0d.cpu_rst", k), {31'h0, crst}, {31'h0, m_st[k] != 2});
    chk($sformatf("dut%0d.done", k), {31'h0, done}, {31'h0, m_st[k] == 2});
    chk($sformatf("dut%0d.ready", k), {31'h0, ready}, {31'h0, m_st[k] == 1});
    chk($sformatf("dut%0d.err", k), {31'h0, err}, {31'h0, m_err[k]});
    chk($sformatf("dut%0d.word_count", k), wc, m_wc[k]);
    idx = int'(addr / 4) % m_depth[k];
    if (!(ce && m_st[k] == 2)) chk($sformatf("dut%0d.rom_data", k), data, 32'h0);
    else if (m_vld[k][idx]) chk($sformatf("dut%0d.rom_data", k), data, m_mem[k][idx]);
  endtask

  always @(posedge clk) begin
    model_step(0, rst, ifa.ld_start_i, ifa.ld_run_i, ifa.ld_valid_i, ifa.ld_byte_i, ifa.ld_last_i);
    model_step(1, rst, ifb.ld_start_i, ifb.ld_run_i, ifb.ld_valid_i, ifb.ld_byte_i, ifb.ld_last_i);
    #1;
    if (cmp_en) begin
      compare(0, ifa.rom_ce_i, ifa.rom_addr_i, ifa.rom_data_o, ifa.ld_ready_o, ifa.ld_done_o,
              ifa.ld_err_o, 32'(ifa.word_count_o), ifa.cpu_rst_o);
      compare(1, ifb.rom_ce_i, ifb.rom_addr_i, ifb.rom_data_o, ifb.ld_ready_o, ifb.ld_done_o,
              ifb.ld_err_o, 32'(ifb.word_count_o), ifb.cpu_rst_o);
    end
  end

  task automatic send(input int k, input logic [7:0] b, input logic last);
    @(negedge clk);
    if (k == 0) begin ifa.ld_valid_i = 1; ifa.ld_byte_i = b; ifa.ld_last_i = last; end
    else        begin ifb.ld_valid_i = 1; ifb.ld_byte_i = b; ifb.ld_last_i = last; end
    @(negedge clk);
    ifa.ld_valid_i = 0; ifa.ld_last_i = 0;
    ifb.ld_valid_i = 0; ifb.ld_last_i = 0;
  endtask

  task automatic pulse(input int k, input logic start, input logic run);
    @(negedge clk);
    if (k == 0) begin ifa.ld_start_i = start; ifa.ld_run_i = run; end
    else        begin ifb.ld_start_i = start; ifb.ld_run_i = run; end
    @(negedge clk);
    ifa.ld_start_i = 0; ifa.ld_run_i = 0;
    ifb.ld_start_i = 0; ifb.ld_run_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  task automatic fetch_a(input logic [31:0] addr, input logic [31:0] exp, input string name);
    ifa.rom_ce_i = 1; ifa.rom_addr_i = addr; #1;
    chk(name, ifa.rom_data_o, exp);
  endtask

  logic [7:0] img1 [8];

  initial begin
    m_depth[0] = 1024; m_depth[1] = 4;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_clear(k);
      for (int j = 0; j < 1024; j++) m_vld[k][j] = 0;
    end
    img1 = '{8'h34, 8'h02, 8'h00, 8'h01, 8'h34, 8'h03, 8'h00, 8'h02};
    rst = 1;
    ifa.rom_ce_i = 0; ifa.rom_addr_i = 0; ifa.ld_start_i = 0; ifa.ld_run_i = 0;
    ifa.ld_valid_i = 0; ifa.ld_byte_i = 0; ifa.ld_last_i = 0;
    ifb.rom_ce_i = 0; ifb.rom_addr_i = 0; ifb.ld_start_i = 0; ifb.ld_run_i = 0;
    ifb.ld_valid_i = 0; ifb.ld_byte_i = 0; ifb.ld_last_i = 0;
    cmp_en = 1;
    @(negedge clk); @(negedge clk);
    rst = 0;
    chk("reset.cpu_rst", {31'h0, ifa.cpu_rst_o}, 32'h1);
    chk("reset.word_count", 32'(ifa.word_count_o), 32'h0);

    // two-word image; rom_ce held high so the load phase must read 0
    ifa.rom_ce_i = 1;
    pulse(0, 1, 0);
    for (int i = 0; i < 8; i++) send(0, img1[i], i == 7);
    chk("img1.word_count", 32'(ifa.word_count_o), 32'd2);
    chk("img1.done", {31'h0, ifa.ld_done_o}, 32'h1);
    chk("img1.cpu_rst", {31'h0, ifa.cpu_rst_o}, 32'h0);
    fetch_a(32'd0, 32'h34020001, "img1.word0");
    fetch_a(32'd4, 32'h34030002, "img1.word1");

    // partial trailing word
    pulse(0, 1, 0);
    send(0, 8'hAA, 0); send(0, 8'hBB, 0); send(0, 8'hCC, 0); send(0, 8'hDD, 0);
    send(0, 8'hEE, 1);
    chk("part.word_count", 32'(ifa.word_count_o), 32'd2);
    fetch_a(32'd7, 32'hEE000000, "part.addr7");
    fetch_a(32'd1, 32'hAABBCCDD, "part.addr1");
    fetch_a(32'd4100, 32'hEE000000, "part.alias");

    // overflow on the 4-word instance
    ifb.rom_ce_i = 1; ifb.rom_addr_i = 0;
    pulse(1, 1, 0);
    for (int i = 0; i < 17; i++) send(1, 8'(8'h10 + i), i == 16);
    chk("ovf.err", {31'h0, ifb.ld_err_o}, 32'h1);
    chk("ovf.word_count", 32'(ifb.word_count_o), 32'd4);
    chk("ovf.done", {31'h0, ifb.ld_done_o}, 32'h1);
    #1 chk("ovf.mem0", ifb.rom_data_o, 32'h10111213);
    ifb.rom_addr_i = 12; #1 chk("ovf.mem3", ifb.rom_data_o, 32'h1C1D1E1F);

    // reset in the middle of a session
    pulse(0, 1, 0);
    for (int i = 0; i < 6; i++) send(0, 8'(i + 1), 0);
    do_reset();
    chk("midrst.cpu_rst", {31'h0, ifa.cpu_rst_o}, 32'h1);
    chk("midrst.word_count", 32'(ifa.word_count_o), 32'h0);
    chk("midrst.ready", {31'h0, ifa.ld_ready_o}, 32'h0);
    pulse(0, 0, 1);
    fetch_a(32'd0, 32'h01020304, "midrst.mem0");
    fetch_a(32'd4, 32'hEE000000, "midrst.mem1");
    pulse(0, 1, 0);
    send(0, 8'h11, 0); send(0, 8'h22, 0); send(0, 8'h33, 0); send(0, 8'h44, 1);
    chk("reload.word_count", 32'(ifa.word_count_o), 32'd1);
    fetch_a(32'd0, 32'h11223344, "reload.mem0");

    // ld_start from RUN with err pending
    pulse(1, 1, 0);
    chk("rerun.cpu_rst", {31'h0, ifb.cpu_rst_o}, 32'h1);
    chk("rerun.err", {31'h0, ifb.ld_err_o}, 32'h0);
    ifb.rom_addr_i = 0; #1 chk("rerun.rom_zero", ifb.rom_data_o, 32'h0);
    send(1, 8'h99, 1);
    #1 chk("rerun.mem0", ifb.rom_data_o, 32'h99000000);

    // reset then run existing contents; start beats run in IDLE
    do_reset();
    @(negedge clk);
    ifa.ld_run_i = 1; ifb.ld_start_i = 1; ifb.ld_run_i = 1;
    @(negedge clk);
    ifa.ld_run_i = 0; ifb.ld_start_i = 0; ifb.ld_run_i = 0;
    chk("run.cpu_rst", {31'h0, ifa.cpu_rst_o}, 32'h0);
    chk("prio.ready", {31'h0, ifb.ld_ready_o}, 32'h1);
    fetch_a(32'd0, 32'h11223344, "run.mem0");
    ifa.rom_ce_i = 0; #1 chk("run.ce_off", ifa.rom_data_o, 32'h0);
    ifb.ld_run_i = 1;
    @(negedge clk); ifb.ld_run_i = 0;
    chk("load.run_ignored", {31'h0, ifb.ld_ready_o}, 32'h1);
    repeat (3) @(negedge clk);
    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
